sram_arbiter_n: RTL

//   N-port arbiter funnelling independent requesters into the single-request SRAM controller

---
 rtl/sram_arbiter_n.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_n.sv
`timescale 1ns/1ps
// sram_arbiter_n
//   Funnels NUM_PORTS independent requesters into the single-request SRAM
//   controller port. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Arbitration is round-robin
//   (ARB_MODE 0) or fixed priority with port 0 highest (ARB_MODE 1). A
//   watchdog aborts a grant stuck in WAIT for TIMEOUT_CYC cycles (0 = off).
// Ports
//   clk, rst_n            SRAM clock, synchronous active-low reset
//   p_req/p_wr            per-port request level and write select
//   p_addr/p_wdata        packed per-port address / write data
//   p_rdata               shared read data, valid with p_done
//   p_done/p_err          one-cycle completion / abort pulse to the owner
//   grant                 one-hot current owner, zero in IDLE
//   m_req/m_wr/m_rd       one-cycle request and strobes to the controller
//   m_addr/m_wdata        latched address / write data of the owner
//   m_rdata/m_valid       controller read data and completion pulse
//   m_busy                controller cannot accept a request
module sram_arbiter_n #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            p_req,
    input  logic [NUM_PORTS-1:0]            p_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]            p_done,
    output logic [NUM_PORTS-1:0]            p_err,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            m_req,
    output logic                            m_wr,
    output logic                            m_rd,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_valid,
    input  logic                            m_busy
);

    localparam int unsigned IW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [NUM_PORTS-1:0]   grant_r;
    logic [IW-1:0]          gidx_r;
    logic [IW-1:0]          ptr;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic                   wr_r;
    logic [DATA_WIDTH-1:0]  rdata_r;
    logic [CW-1:0]          wd_cnt;
    logic                   err_r;

    logic [IW-1:0]          win_idx;
    logic                   win_hit;
    logic [IW:0]            rr_sum;
    logic [IW-1:0]          rr_cand;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_wr;
    logic                   timeout_hit;

    // Winner selection. Round-robin walks upward from ptr with wrap, which
    // for non-power-of-two port counts needs an explicit modulo step.
    always_comb begin
        win_idx = '0;
        win_hit = 1'b0;
        rr_sum  = '0;
        rr_cand = '0;
        if (ARB_MODE == 0) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                rr_sum = {1'b0, ptr} + (IW+1)'(k);
                if (rr_sum >= (IW+1)'(NUM_PORTS))
                    rr_sum = rr_sum - (IW+1)'(NUM_PORTS);
                rr_cand = rr_sum[IW-1:0];
                if (!win_hit && p_req[rr_cand]) begin
                    win_idx = rr_cand;
                    win_hit = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!win_hit && p_req[i]) begin
                    win_idx = IW'(i);
                    win_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == IW'(i)) begin
                sel_addr  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wr    = p_wr[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (wd_cnt == CW'(TO_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (win_hit && !m_busy) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (m_valid || timeout_hit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Transaction datapath: owner, latched request, watchdog and pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_r <= '0;
            gidx_r  <= '0;
            ptr     <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            wr_r    <= 1'b0;
            rdata_r <= '0;
            wd_cnt  <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_hit && !m_busy) begin
                        grant_r <= NUM_PORTS'(1) << win_idx;
                        gidx_r  <= win_idx;
                        addr_r  <= sel_addr;
                        wdata_r <= sel_wdata;
                        wr_r    <= sel_wr;
                        err_r   <= 1'b0;
                    end
                end
                S_ISSUE: wd_cnt <= '0;
                S_WAIT: begin
                    // m_valid takes precedence over a coincident timeout
                    if (m_valid)
                        rdata_r <= m_rdata;
                    else if (timeout_hit)
                        err_r <= 1'b1;
                    else
                        wd_cnt <= wd_cnt + 1'b1;
                end
                S_DONE: begin
                    grant_r <= '0;
                    if (ARB_MODE == 0)
                        ptr <= (gidx_r == IW'(NUM_PORTS - 1)) ? '0 : gidx_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        m_req  = (state == S_ISSUE);
        m_wr   = (state == S_ISSUE) &&  wr_r;
        m_rd   = (state == S_ISSUE) && !wr_r;
        p_done = (state == S_DONE) ? grant_r : '0;
        p_err  = (state == S_DONE && err_r) ? grant_r : '0;
    end

    assign grant   = grant_r;
    assign m_addr  = addr_r;
    assign m_wdata = wdata_r;
    assign p_rdata = rdata_r;

endmodule
